// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 raster timing constants, test-pattern encodings and the
// per-pixel record carried alongside the renderer pipeline.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;

    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef enum logic [1:0] {
        PAT_SCENE = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_WHITE = 2'd3
    } pat_sel_t;

    typedef struct packed {
        logic     hs;
        logic     vs;
        logic     act;
        logic     fs;
        logic [2:0] bar;
        logic     chk;
        pat_sel_t sel;
    } pipe_t;

    // Idle entry: syncs deasserted, blanked, so a refilling pipe never pulses sync.
    localparam pipe_t PIPE_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0,
                                    bar: 3'd0, chk: 1'b0, sel: PAT_SCENE};

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear to RST_VAL; depth 0 is a
// plain wire. Latency DEPTH cycles, no backpressure.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_dat    = i_dat;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_dat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// VGA pin stage: realigns sync/enable with renderer colour, blanks, overlays test
// patterns, counts frames. Counts->pins RENDER_LAT+1 cycles, colour->pins 1; no backpressure.
module vga_out_stage
    import vga_timing_pkg::*;
#(
    parameter int RENDER_LAT = 2,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        h_count,
    input  logic [9:0]         v_count,
    input  logic [1:0]         r_in,
    input  logic [1:0]         g_in,
    input  logic [1:0]         b_in,
    input  logic [1:0]         pattern_sel,
    output logic               hsync,
    output logic               vsync,
    output logic [1:0]         r_out,
    output logic [1:0]         g_out,
    output logic [1:0]         b_out,
    output logic               de,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    pat_sel_t           r_active_sel;
    pipe_t              w_s0;
    pipe_t              w_dl;
    logic [1:0]         w_r, w_g, w_b;
    logic               r_hsync, r_vsync, r_de, r_frame_start;
    logic [1:0]         r_r, r_g, r_b;
    logic [FRAME_W-1:0] r_frame_cnt;

    always_comb begin
        w_s0     = PIPE_IDLE;
        w_s0.hs  = !((h_count >= 11'(H_SYNC_START)) && (h_count < 11'(H_SYNC_END)));
        w_s0.vs  = !((v_count >= 10'(V_SYNC_START)) && (v_count < 10'(V_SYNC_END)));
        w_s0.act = (h_count < 11'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));
        w_s0.fs  = (h_count == 11'd0) && (v_count == 10'd0);
        w_s0.bar = h_count[9:7];
        w_s0.chk = h_count[5] ^ v_count[5];
        // Pixel (0,0) already uses the selection captured on its own cycle.
        w_s0.sel = w_s0.fs ? pat_sel_t'(pattern_sel) : r_active_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_sel <= PAT_SCENE;
        end else if (w_s0.fs) begin
            r_active_sel <= pat_sel_t'(pattern_sel);
        end
    end

    vga_delay_line #(
        .WIDTH   ($bits(pipe_t)),
        .DEPTH   (RENDER_LAT),
        .RST_VAL (PIPE_IDLE)
    ) u_delay (
        .i_clk (clk),
        .i_rst (rst),
        .i_dat (w_s0),
        .o_dat (w_dl)
    );

    always_comb begin
        w_r = 2'd0;
        w_g = 2'd0;
        w_b = 2'd0;
        if (w_dl.act) begin
            case (w_dl.sel)
                PAT_SCENE: begin
                    w_r = r_in;
                    w_g = g_in;
                    w_b = b_in;
                end
                PAT_BARS: begin
                    w_r = {2{w_dl.bar[2]}};
                    w_g = {2{w_dl.bar[1]}};
                    w_b = {2{w_dl.bar[0]}};
                end
                PAT_CHECK: begin
                    w_r = {2{w_dl.chk}};
                    w_g = {2{w_dl.chk}};
                    w_b = {2{w_dl.chk}};
                end
                default: begin
                    w_r = 2'b11;
                    w_g = 2'b11;
                    w_b = 2'b11;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_r           <= 2'd0;
            r_g           <= 2'd0;
            r_b           <= 2'd0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_hsync       <= w_dl.hs;
            r_vsync       <= w_dl.vs;
            r_de          <= w_dl.act;
            r_r           <= w_r;
            r_g           <= w_g;
            r_b           <= w_b;
            r_frame_start <= w_dl.fs;
            r_frame_cnt   <= r_frame_cnt + FRAME_W'(w_dl.fs);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign r_out       = r_r;
    assign g_out       = r_g;
    assign b_out       = r_b;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_out_stage.sv
// Directed bench: dut_a (RENDER_LAT=2, FRAME_W=2) and dut_b (RENDER_LAT=0, FRAME_W=8)
// share counts/reset/pattern_sel; each has its own colour inputs.
`timescale 1ns/1ps
module tb_vga_out_stage;

    localparam logic [10:0] FILL_H  = 11'd645;
    localparam logic [9:0]  FILL_V  = 10'd20;
    localparam logic [9:0]  RST_VEC = 10'b1100_000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic [1:0]  pattern_sel;
    logic [5:0]  col_a, col_b;

    logic       a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
    logic [1:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic [1:0] a_cnt;
    logic [7:0] b_cnt, b_snap_cnt;
    logic [9:0] a_vec, b_vec, b_snap, a_pre;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_vec = {a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b};
    assign b_vec = {b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b};

    vga_out_stage #(.RENDER_LAT(2), .FRAME_W(2)) dut_a (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .r_in(col_a[5:4]), .g_in(col_a[3:2]), .b_in(col_a[1:0]), .pattern_sel(pattern_sel),
        .hsync(a_hs), .vsync(a_vs), .r_out(a_r), .g_out(a_g), .b_out(a_b),
        .de(a_de), .frame_start(a_fs), .frame_cnt(a_cnt)
    );

    vga_out_stage #(.RENDER_LAT(0), .FRAME_W(8)) dut_b (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .r_in(col_b[5:4]), .g_in(col_b[3:2]), .b_in(col_b[1:0]), .pattern_sel(pattern_sel),
        .hsync(b_hs), .vsync(b_vs), .r_out(b_r), .g_out(b_g), .b_out(b_b),
        .de(b_de), .frame_start(b_fs), .frame_cnt(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] hh, input logic [9:0] vv,
                         input logic [5:0] ca, input logic [5:0] cb);
        h_count = hh;
        v_count = vv;
        col_a   = ca;
        col_b   = cb;
    endtask

    // One pixel then two fillers: dut_b is snapshotted after the first edge,
    // dut_a shows the pixel after the third edge with colour from the third cycle.
    task automatic pix3(input logic [10:0] hh, input logic [9:0] vv, input logic [5:0] col);
        drive(hh, vv, 6'd0, col);
        tick();
        b_snap     = b_vec;
        b_snap_cnt = b_cnt;
        drive(FILL_H, FILL_V, 6'd0, 6'd0);
        tick();
        a_pre = a_vec;
        drive(FILL_H, FILL_V, col, 6'd0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pattern_sel = 2'd3;
        drive(11'd0, 10'd0, 6'h3f, 6'h3f);
        repeat (3) tick();
        checks++; if (a_vec !== RST_VEC) begin errors++; $display("FAIL reset a_vec: got %b expected %b", a_vec, RST_VEC); end
        checks++; if (b_vec !== RST_VEC) begin errors++; $display("FAIL reset b_vec: got %b expected %b", b_vec, RST_VEC); end
        checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL reset a_cnt: got %0d expected 0", a_cnt); end
        checks++; if (b_cnt !== 8'd0) begin errors++; $display("FAIL reset b_cnt: got %0d expected 0", b_cnt); end
        rst = 1'b0;
        pattern_sel = 2'd0;
        drive(FILL_H, FILL_V, 6'd0, 6'd0);
        repeat (3) tick();
    endtask

    task automatic test_latency();
        pix3(11'd0, 10'd0, 6'b11_00_10);
        checks++; if (a_pre !== RST_VEC) begin errors++; $display("FAIL latency a_early: got %b expected %b", a_pre, RST_VEC); end
        checks++; if (a_vec !== 10'b1111_110010) begin errors++; $display("FAIL latency a_vec: got %b expected %b", a_vec, 10'b1111_110010); end
        checks++; if (a_cnt !== 2'd1) begin errors++; $display("FAIL latency a_cnt: got %0d expected 1", a_cnt); end
        checks++; if (b_snap !== 10'b1111_110010) begin errors++; $display("FAIL latency b_vec: got %b expected %b", b_snap, 10'b1111_110010); end
        checks++; if (b_snap_cnt !== 8'd1) begin errors++; $display("FAIL latency b_cnt: got %0d expected 1", b_snap_cnt); end
        pix3(11'd1, 10'd0, 6'b00_00_11);
        checks++; if (a_vec !== 10'b1110_000011) begin errors++; $display("FAIL second_pixel a_vec: got %b expected %b", a_vec, 10'b1110_000011); end
        checks++; if (b_snap !== 10'b1110_000011) begin errors++; $display("FAIL second_pixel b_vec: got %b expected %b", b_snap, 10'b1110_000011); end
        checks++; if (a_cnt !== 2'd1) begin errors++; $display("FAIL second_pixel a_cnt: got %0d expected 1", a_cnt); end
    endtask

    task automatic test_sync();
        logic [10:0] th [9] = '{11'd655, 11'd656, 11'd751, 11'd752, 11'd100, 11'd100, 11'd100, 11'd100, 11'd700};
        logic [9:0]  tv [9] = '{10'd10, 10'd10, 10'd10, 10'd10, 10'd489, 10'd490, 10'd491, 10'd492, 10'd490};
        logic [1:0]  ts [9] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [9:0]  exp;
        for (int i = 0; i < 9; i++) begin
            pix3(th[i], tv[i], 6'h3f);
            exp = {ts[i], 8'd0};
            checks++; if (a_vec !== exp) begin errors++; $display("FAIL sync a h=%0d v=%0d: got %b expected %b", th[i], tv[i], a_vec, exp); end
            checks++; if (b_snap !== exp) begin errors++; $display("FAIL sync b h=%0d v=%0d: got %b expected %b", th[i], tv[i], b_snap, exp); end
        end
    endtask

    task automatic test_blank();
        logic [10:0] th [3] = '{11'd640, 11'd639, 11'd0};
        logic [9:0]  tv [3] = '{10'd0, 10'd479, 10'd480};
        logic [5:0]  tc [3] = '{6'h3f, 6'b11_01_10, 6'h3f};
        logic [9:0]  te [3] = '{10'b1100_000000, 10'b1110_110110, 10'b1100_000000};
        for (int i = 0; i < 3; i++) begin
            pix3(th[i], tv[i], tc[i]);
            checks++; if (a_vec !== te[i]) begin errors++; $display("FAIL blank a h=%0d v=%0d: got %b expected %b", th[i], tv[i], a_vec, te[i]); end
            checks++; if (b_snap !== te[i]) begin errors++; $display("FAIL blank b h=%0d v=%0d: got %b expected %b", th[i], tv[i], b_snap, te[i]); end
        end
    endtask

    task automatic test_patterns();
        logic [1:0]  tp [12] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [10:0] th [12] = '{11'd130, 11'd0, 11'd130, 11'd520, 11'd300, 11'd0,
                                 11'd32, 11'd32, 11'd700, 11'd0, 11'd10, 11'd0};
        logic [9:0]  tv [12] = '{10'd100, 10'd0, 10'd5, 10'd5, 10'd5, 10'd0,
                                 10'd0, 10'd32, 10'd40, 10'd0, 10'd10, 10'd0};
        logic [5:0]  tc [12] = '{6'b010101, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f,
                                 6'h00, 6'h3f, 6'h3f, 6'h00, 6'h00, 6'b000110};
        logic [9:0]  te [12] = '{10'b1110_010101, 10'b1111_000000, 10'b1110_000011, 10'b1110_110000,
                                 10'b1110_001100, 10'b1111_000000, 10'b1110_111111, 10'b1110_000000,
                                 10'b0100_000000, 10'b1111_111111, 10'b1110_111111, 10'b1111_000110};
        logic [1:0]  ta [12] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        logic [7:0]  tb [12] = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5};
        for (int i = 0; i < 12; i++) begin
            pattern_sel = tp[i];
            pix3(th[i], tv[i], tc[i]);
            checks++; if (a_vec !== te[i]) begin errors++; $display("FAIL pattern a #%0d: got %b expected %b", i, a_vec, te[i]); end
            checks++; if (b_snap !== te[i]) begin errors++; $display("FAIL pattern b #%0d: got %b expected %b", i, b_snap, te[i]); end
            checks++; if (a_cnt !== ta[i]) begin errors++; $display("FAIL pattern a_cnt #%0d: got %0d expected %0d", i, a_cnt, ta[i]); end
            checks++; if (b_snap_cnt !== tb[i]) begin errors++; $display("FAIL pattern b_cnt #%0d: got %0d expected %0d", i, b_snap_cnt, tb[i]); end
        end
        pattern_sel = 2'd0;
    endtask

    task automatic test_frame_count();
        logic [10:0] fh [10] = '{11'd0, 11'd1, 11'd656, 11'd700, 11'd0, 11'd656, 11'd10, 11'd799, 11'd20, 11'd645};
        logic [9:0]  fv [10] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd300, 10'd490, 10'd491, 10'd524, 10'd100, 10'd20};
        int na, nb;
        rst = 1'b1;
        drive(FILL_H, FILL_V, 6'd0, 6'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int f = 0; f < 5; f++) begin
            na = 0;
            nb = 0;
            for (int p = 0; p < 10; p++) begin
                drive(fh[p], fv[p], 6'd0, 6'd0);
                tick();
                if (a_fs === 1'b1) na++;
                if (b_fs === 1'b1) nb++;
            end
            checks++; if (na != 1) begin errors++; $display("FAIL frame%0d a_pulses: got %0d expected 1", f, na); end
            checks++; if (nb != 1) begin errors++; $display("FAIL frame%0d b_pulses: got %0d expected 1", f, nb); end
            checks++; if (a_cnt !== 2'(f + 1)) begin errors++; $display("FAIL frame%0d a_cnt: got %0d expected %0d", f, a_cnt, (f + 1) % 4); end
            checks++; if (b_cnt !== 8'(f + 1)) begin errors++; $display("FAIL frame%0d b_cnt: got %0d expected %0d", f, b_cnt, f + 1); end
        end
    endtask

    task automatic test_reset_midline();
        drive(11'd298, 10'd200, 6'h3f, 6'h3f); tick();
        drive(11'd299, 10'd200, 6'h3f, 6'h3f); tick();
        drive(11'd300, 10'd200, 6'h3f, 6'h3f); tick();
        checks++; if (a_vec !== 10'b1110_111111) begin errors++; $display("FAIL midline_pre a_vec: got %b expected %b", a_vec, 10'b1110_111111); end
        checks++; if (b_vec !== 10'b1110_111111) begin errors++; $display("FAIL midline_pre b_vec: got %b expected %b", b_vec, 10'b1110_111111); end
        rst = 1'b1;
        drive(11'd301, 10'd200, 6'h3f, 6'h3f); tick();
        checks++; if (a_vec !== RST_VEC) begin errors++; $display("FAIL midline_rst a_vec: got %b expected %b", a_vec, RST_VEC); end
        checks++; if (b_vec !== RST_VEC) begin errors++; $display("FAIL midline_rst b_vec: got %b expected %b", b_vec, RST_VEC); end
        checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL midline_rst a_cnt: got %0d expected 0", a_cnt); end
        checks++; if (b_cnt !== 8'd0) begin errors++; $display("FAIL midline_rst b_cnt: got %0d expected 0", b_cnt); end
        rst = 1'b0;
        drive(11'd656, 10'd200, 6'd0, 6'd0); tick();
        checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL refill1 a_hsync: got %b expected 1", a_hs); end
        checks++; if (b_hs !== 1'b0) begin errors++; $display("FAIL refill1 b_hsync: got %b expected 0", b_hs); end
        drive(11'd657, 10'd200, 6'd0, 6'd0); tick();
        checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL refill2 a_hsync: got %b expected 1", a_hs); end
        drive(11'd658, 10'd200, 6'd0, 6'd0); tick();
        checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL refill3 a_hsync: got %b expected 0", a_hs); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sync();
        test_blank();
        test_patterns();
        test_frame_count();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
